// File: rtl/and_gate.sv
// ---------------------------------------------------------------------------
// and_gate
//
// Bitwise AND cell with a small amount of observable status around it.
// The combinational result is available with zero latency. Alongside it are
// a registered copy, per-bit rising-edge pulses and a saturating count of
// the cycles in which every bit of the result was high.
//
// Parameters:
//   WIDTH     - width of operands a, b and of results out, out_q, rise
//   CNT_W     - width of the saturating high-cycle counter
//
// Ports:
//   clk       - system clock, rising-edge active
//   rst       - synchronous reset, active-high
//   a, b      - operands
//   out       - combinational a & b (independent of clk and rst)
//   out_q     - a & b registered, one cycle of latency
//   rise      - one-cycle pulse per bit when out_q goes 0 -> 1
//   all_high  - combinational reduction AND of out
//   high_cnt  - saturating count of edges at which all_high was 1
//   cnt_sat   - high_cnt is at its maximum value
// ---------------------------------------------------------------------------
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] rise,
    output logic             all_high,
    output logic [CNT_W-1:0] high_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_andResult;
    logic             w_allHigh;
    logic             w_cntSat;

    logic [WIDTH-1:0] r_outQ;
    logic [WIDTH-1:0] r_rise;
    logic [CNT_W-1:0] r_highCnt;

    // The gate itself. Kept free of any clock or reset so that the pure
    // logic function is usable even when nothing is clocking the block.
    assign w_andResult = a & b;
    assign w_allHigh   = &w_andResult;
    assign w_cntSat    = (r_highCnt == CNT_MAX);

    // Registered status. The rise detector compares the new result against
    // out_q as it was before this edge, so a bit that stays high pulses only
    // once. The counter holds at its maximum instead of wrapping so that a
    // long run of high cycles never looks like a short one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outQ    <= '0;
            r_rise    <= '0;
            r_highCnt <= '0;
        end else begin
            r_outQ <= w_andResult;
            r_rise <= w_andResult & ~r_outQ;
            if (w_allHigh && !w_cntSat) begin
                r_highCnt <= r_highCnt + CNT_W'(1);
            end
        end
    end

    assign out      = w_andResult;
    assign all_high = w_allHigh;
    assign out_q    = r_outQ;
    assign rise     = r_rise;
    assign high_cnt = r_highCnt;
    assign cnt_sat  = w_cntSat;

endmodule

// File: tb/tb_and_gate.sv
// ---------------------------------------------------------------------------
// tb_and_gate
//
// Directed bench for and_gate. Two instances share one clock:
//   dutA - WIDTH=1, CNT_W=3  (truth table, registered path, saturation,
//          mid-count reset, back-to-back toggling)
//   dutB - WIDTH=4, CNT_W=16 (vector behaviour and per-bit rise pulses)
// The clock is held still until the combinational test has finished.
// ---------------------------------------------------------------------------
module tb_and_gate;

    logic clk = 1'b0;
    bit   clkEn = 1'b0;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic       rstA, aA, bA;
    logic       outA, outQA, riseA, allHighA, satA;
    logic [2:0] cntA;

    // Instance B signals
    logic        rstB;
    logic [3:0]  aB, bB, outB, outQB, riseB;
    logic        allHighB, satB;
    logic [15:0] cntB;

    and_gate #(.WIDTH(1), .CNT_W(3)) dutA (
        .clk(clk), .rst(rstA), .a(aA), .b(bA),
        .out(outA), .out_q(outQA), .rise(riseA),
        .all_high(allHighA), .high_cnt(cntA), .cnt_sat(satA)
    );

    and_gate #(.WIDTH(4), .CNT_W(16)) dutB (
        .clk(clk), .rst(rstB), .a(aB), .b(bB),
        .out(outB), .out_q(outQB), .rise(riseB),
        .all_high(allHighB), .high_cnt(cntB), .cnt_sat(satB)
    );

    // Clock only toggles once enabled.
    always #5 if (clkEn) clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pure gate function with no clock running.
    task automatic test_comb();
        logic va[4];
        logic vb[4];
        logic ve[4];
        va = '{1'b0, 1'b1, 1'b1, 1'b0};
        vb = '{1'b1, 1'b0, 1'b1, 1'b0};
        ve = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            aA = va[i];
            bA = vb[i];
            #1;
            total++;
            if (outA !== ve[i]) begin
                bad++;
                $display("[TB] FAIL comb_out[%0d] got %b want %b", i, outA, ve[i]);
            end
            total++;
            if (allHighA !== ve[i]) begin
                bad++;
                $display("[TB] FAIL comb_all_high[%0d] got %b want %b", i, allHighA, ve[i]);
            end
            #2;
        end
    endtask

    // Registered outputs held clear while reset is asserted.
    task automatic test_reset();
        clkEn = 1'b1;
        rstA = 1'b1;
        aA = 1'b1;
        bA = 1'b1;
        repeat (2) tick();
        total++;
        if (outQA !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_q got %b want 0", outQA); end
        total++;
        if (riseA !== 1'b0) begin bad++; $display("[TB] FAIL reset_rise got %b want 0", riseA); end
        total++;
        if (cntA !== 3'd0) begin bad++; $display("[TB] FAIL reset_cnt got %0d want 0", cntA); end
        total++;
        if (satA !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat got %b want 0", satA); end
        total++;
        if (outA !== 1'b1) begin bad++; $display("[TB] FAIL reset_out got %b want 1", outA); end
    endtask

    // First edge after release loads out_q and pulses rise exactly once.
    task automatic test_registered();
        rstA = 1'b0;
        tick();
        total++;
        if (outQA !== 1'b1) begin bad++; $display("[TB] FAIL reg_out_q1 got %b want 1", outQA); end
        total++;
        if (riseA !== 1'b1) begin bad++; $display("[TB] FAIL reg_rise1 got %b want 1", riseA); end
        total++;
        if (cntA !== 3'd1) begin bad++; $display("[TB] FAIL reg_cnt1 got %0d want 1", cntA); end
        tick();
        total++;
        if (outQA !== 1'b1) begin bad++; $display("[TB] FAIL reg_out_q2 got %b want 1", outQA); end
        total++;
        if (riseA !== 1'b0) begin bad++; $display("[TB] FAIL reg_rise2 got %b want 0", riseA); end
    endtask

    // Counter steps to 7 and holds; low cycles do not advance it.
    task automatic test_saturate();
        logic [2:0] expCnt;
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        aA = 1'b1;
        bA = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expCnt = (i > 7) ? 3'd7 : 3'(i);
            total++;
            if (cntA !== expCnt) begin
                bad++;
                $display("[TB] FAIL sat_cnt[%0d] got %0d want %0d", i, cntA, expCnt);
            end
            total++;
            if (satA !== (expCnt == 3'd7)) begin
                bad++;
                $display("[TB] FAIL sat_flag[%0d] got %b want %b", i, satA, (expCnt == 3'd7));
            end
        end
        bA = 1'b0;
        #1;
        total++;
        if (allHighA !== 1'b0) begin bad++; $display("[TB] FAIL sat_all_high_low got %b want 0", allHighA); end
        tick();
        total++;
        if (cntA !== 3'd7) begin bad++; $display("[TB] FAIL sat_hold_cnt got %0d want 7", cntA); end
        total++;
        if (outQA !== 1'b0) begin bad++; $display("[TB] FAIL sat_out_q_low got %b want 0", outQA); end
        bA = 1'b1;
        tick();
        total++;
        if (riseA !== 1'b1) begin bad++; $display("[TB] FAIL sat_rise_again got %b want 1", riseA); end
        total++;
        if (cntA !== 3'd7) begin bad++; $display("[TB] FAIL sat_still_7 got %0d want 7", cntA); end
    endtask

    // Reset in the middle of a count clears everything on that edge.
    task automatic test_reset_mid();
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        aA = 1'b1;
        bA = 1'b1;
        repeat (5) tick();
        total++;
        if (cntA !== 3'd5) begin bad++; $display("[TB] FAIL mid_cnt5 got %0d want 5", cntA); end
        rstA = 1'b1;
        #1;
        total++;
        if (outA !== 1'b1) begin bad++; $display("[TB] FAIL mid_out_in_rst got %b want 1", outA); end
        tick();
        total++;
        if (cntA !== 3'd0) begin bad++; $display("[TB] FAIL mid_cnt_clr got %0d want 0", cntA); end
        total++;
        if (outQA !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_q_clr got %b want 0", outQA); end
        total++;
        if (riseA !== 1'b0) begin bad++; $display("[TB] FAIL mid_rise_clr got %b want 0", riseA); end
        total++;
        if (outA !== 1'b1) begin bad++; $display("[TB] FAIL mid_out_after got %b want 1", outA); end
        rstA = 1'b0;
        tick();
        total++;
        if (riseA !== 1'b1) begin bad++; $display("[TB] FAIL mid_rise_post got %b want 1", riseA); end
        total++;
        if (cntA !== 3'd1) begin bad++; $display("[TB] FAIL mid_cnt_post got %0d want 1", cntA); end
    endtask

    // WIDTH=4: per-bit behaviour and rise against the previous out_q.
    task automatic test_vector();
        rstB = 1'b1;
        aB = 4'b0000;
        bB = 4'b0000;
        tick();
        rstB = 1'b0;
        aB = 4'b1100;
        bB = 4'b1010;
        #1;
        total++;
        if (outB !== 4'b1000) begin bad++; $display("[TB] FAIL vec_out got %b want 1000", outB); end
        total++;
        if (allHighB !== 1'b0) begin bad++; $display("[TB] FAIL vec_all_high0 got %b want 0", allHighB); end
        tick();
        total++;
        if (outQB !== 4'b1000) begin bad++; $display("[TB] FAIL vec_out_q got %b want 1000", outQB); end
        total++;
        if (riseB !== 4'b1000) begin bad++; $display("[TB] FAIL vec_rise0 got %b want 1000", riseB); end
        total++;
        if (cntB !== 16'd0) begin bad++; $display("[TB] FAIL vec_cnt0 got %0d want 0", cntB); end
        aB = 4'b1111;
        bB = 4'b1111;
        #1;
        total++;
        if (outB !== 4'b1111) begin bad++; $display("[TB] FAIL vec_out_ff got %b want 1111", outB); end
        total++;
        if (allHighB !== 1'b1) begin bad++; $display("[TB] FAIL vec_all_high1 got %b want 1", allHighB); end
        tick();
        total++;
        if (riseB !== 4'b0111) begin bad++; $display("[TB] FAIL vec_rise1 got %b want 0111", riseB); end
        total++;
        if (outQB !== 4'b1111) begin bad++; $display("[TB] FAIL vec_out_q_ff got %b want 1111", outQB); end
        total++;
        if (cntB !== 16'd1) begin bad++; $display("[TB] FAIL vec_cnt1 got %0d want 1", cntB); end
        tick();
        total++;
        if (riseB !== 4'b0000) begin bad++; $display("[TB] FAIL vec_rise_hold got %b want 0000", riseB); end
    endtask

    // Toggling an operand every cycle pulses rise on each 0 -> 1 only.
    task automatic test_back_to_back();
        logic seqA[4];
        logic expQ[4];
        logic expR[4];
        seqA = '{1'b1, 1'b0, 1'b1, 1'b1};
        expQ = '{1'b1, 1'b0, 1'b1, 1'b1};
        expR = '{1'b1, 1'b0, 1'b1, 1'b0};
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        bA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aA = seqA[i];
            tick();
            total++;
            if (outQA !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL b2b_out_q[%0d] got %b want %b", i, outQA, expQ[i]);
            end
            total++;
            if (riseA !== expR[i]) begin
                bad++;
                $display("[TB] FAIL b2b_rise[%0d] got %b want %b", i, riseA, expR[i]);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rstA = 1'b1;
        aA = 1'b0;
        bA = 1'b0;
        rstB = 1'b1;
        aB = 4'b0000;
        bB = 4'b0000;
        test_comb();
        test_reset();
        test_registered();
        test_saturate();
        test_reset_mid();
        test_vector();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
